// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: a DEPTH x DW word store driven by the
// CPU's active-low CEN/WEN/OEN strobes. It also provides a valid/ready preload port, a
// post-reset clear sweep, sticky protocol flags and saturating access counters.
module data_mem_responder #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned DW    = 32,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Data2Mem,
  output logic [DW-1:0] ReadDataMem,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          busy,
  output logic          proto_err,
  output logic          early_err,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] wr_cnt
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CntMax   = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          proto_err_q, proto_err_d;
  logic          early_err_q, early_err_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          cpu_rd, cpu_wr, ld_fire;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Next-state, single write-port arbitration and combinational outputs.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    proto_err_d = proto_err_q;
    early_err_d = early_err_q;
    cpu_rd      = 1'b0;
    cpu_wr      = 1'b0;
    ld_fire     = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_addr_q;
    mem_wdata   = '0;
    busy        = 1'b1;
    ld_ready    = 1'b0;
    ReadDataMem = '0;

    // While reset is held every output stays in its idle value and nothing is written.
    if (rst_n) begin
      case (state_q)
        StClear: begin
          mem_we     = 1'b1;
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == LastAddr) state_d = StReady;
          if (!CEN) early_err_d = 1'b1;
        end
        StReady: begin
          busy     = 1'b0;
          // CPU always has priority over the preload port.
          ld_ready = CEN;
          cpu_rd   = !CEN && !OEN;
          cpu_wr   = !CEN && !WEN;
          ld_fire  = ld_valid && CEN;
          // Read sees pre-edge contents, including on an illegal read+write.
          if (cpu_rd) ReadDataMem = mem_q[A];
          if (cpu_wr) begin
            mem_we    = 1'b1;
            mem_waddr = A;
            mem_wdata = Data2Mem;
          end else if (ld_fire) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr;
            mem_wdata = ld_data;
          end
          if (cpu_rd && rd_cnt_q != CntMax) rd_cnt_d = rd_cnt_q + 1'b1;
          if (cpu_wr && wr_cnt_q != CntMax) wr_cnt_d = wr_cnt_q + 1'b1;
          if (cpu_rd && cpu_wr) proto_err_d = 1'b1;
        end
        default: state_d = StClear;
      endcase
    end
  end

  // Control state with synchronous active-low reset; reset restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_addr_q  <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      proto_err_q <= 1'b0;
      early_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      proto_err_q <= proto_err_d;
      early_err_q <= early_err_d;
    end
  end

  // Storage array; never reset directly, the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign proto_err = proto_err_q;
  assign early_err = early_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural model of the memory, counters and flags.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;
  localparam int unsigned CMAX  = 65535;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CEN = 1'b1, WEN = 1'b1, OEN = 1'b1;
  logic [AW-1:0] A = '0;
  logic [DW-1:0] Data2Mem = '0;
  logic [DW-1:0] ReadDataMem;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          busy, proto_err, early_err;
  logic [CW-1:0] rd_cnt, wr_cnt;

  data_mem_responder #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CEN        (CEN),
    .WEN        (WEN),
    .OEN        (OEN),
    .A          (A),
    .Data2Mem   (Data2Mem),
    .ReadDataMem(ReadDataMem),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .busy       (busy),
    .proto_err  (proto_err),
    .early_err  (early_err),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Behavioural model.
  logic [DW-1:0] mem_m [DEPTH];
  int unsigned   clear_left = 0;
  int unsigned   rd_m = 0, wr_m = 0;
  bit            perr_m = 0, eerr_m = 0, reset_seen = 0;

  // Last observed outputs, for directed checks.
  logic          obs_busy, obs_ld_ready, obs_perr, obs_eerr;
  logic [DW-1:0] obs_rdata;
  logic [CW-1:0] obs_rd_cnt, obs_wr_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs already driven after a negedge; check outputs, then advance model.
  task automatic cycle();
    logic          e_busy, e_ready;
    logic [DW-1:0] e_rdata;
    #1;
    obs_busy = busy; obs_ld_ready = ld_ready; obs_rdata = ReadDataMem;
    obs_perr = proto_err; obs_eerr = early_err; obs_rd_cnt = rd_cnt; obs_wr_cnt = wr_cnt;
    if (!rst_n) begin
      e_busy = 1'b1; e_ready = 1'b0; e_rdata = '0;
    end else begin
      e_busy  = (clear_left != 0);
      e_ready = !e_busy && CEN;
      e_rdata = (!e_busy && !CEN && !OEN) ? mem_m[A] : '0;
    end
    check_eq("busy", 32'(obs_busy), 32'(e_busy));
    check_eq("ld_ready", 32'(obs_ld_ready), 32'(e_ready));
    check_eq("ReadDataMem", obs_rdata, e_rdata);
    if (reset_seen) begin
      check_eq("rd_cnt", 32'(obs_rd_cnt), rd_m);
      check_eq("wr_cnt", 32'(obs_wr_cnt), wr_m);
      check_eq("proto_err", 32'(obs_perr), 32'(perr_m));
      check_eq("early_err", 32'(obs_eerr), 32'(eerr_m));
    end
    @(posedge clk);
    if (!rst_n) begin
      reset_seen = 1; clear_left = DEPTH;
      rd_m = 0; wr_m = 0; perr_m = 0; eerr_m = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (clear_left != 0) begin
      if (!CEN) eerr_m = 1;
      clear_left--;
    end else if (!CEN) begin
      if (!WEN) begin
        mem_m[A] = Data2Mem;
        if (wr_m < CMAX) wr_m++;
      end
      if (!OEN && rd_m < CMAX) rd_m++;
      if (!WEN && !OEN) perr_m = 1;
    end else if (ld_valid) begin
      mem_m[ld_addr] = ld_data;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic cen, input logic wen, input logic oen,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d;
    cycle();
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b1, '0, '0);
  endtask

  // Reset for two cycles, then count busy cycles with the bus idle.
  task automatic reset_and_sweep(input string tag);
    int n;
    rst_n = 1'b0; idle(); idle(); rst_n = 1'b1;
    n = 0;
    do begin
      idle();
      if (obs_busy) n++;
    end while (obs_busy && n < 200);
    check_eq(tag, n, DEPTH);
  endtask

  initial begin
    int n;
    @(negedge clk);

    // Sweep length and cleared contents.
    reset_and_sweep("sweep_len");
    drive(1'b0, 1'b1, 1'b0, 7'd0, '0);   check_eq("clr_a0", obs_rdata, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 7'd5, '0);   check_eq("clr_a5", obs_rdata, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 7'd127, '0); check_eq("clr_a127", obs_rdata, 32'h0);

    // Write then read, fresh counters.
    reset_and_sweep("sweep_len2");
    drive(1'b0, 1'b0, 1'b1, 7'd7, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 1'b0, 7'd7, '0);
    check_eq("wr_rd_a7", obs_rdata, 32'hDEADBEEF);
    idle();
    check_eq("wr_cnt_1", 32'(obs_wr_cnt), 32'd1);
    check_eq("rd_cnt_1", 32'(obs_rd_cnt), 32'd1);

    // Preload stalled by CPU, then accepted.
    ld_valid = 1'b1; ld_addr = 7'd3; ld_data = 32'h12345678;
    drive(1'b0, 1'b1, 1'b1, 7'd0, '0); check_eq("ld_stall0", 32'(obs_ld_ready), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 7'd0, '0); check_eq("ld_stall1", 32'(obs_ld_ready), 32'd0);
    idle();                            check_eq("ld_accept", 32'(obs_ld_ready), 32'd1);
    ld_valid = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 7'd3, '0); check_eq("ld_rd_a3", obs_rdata, 32'h12345678);

    // Illegal read+write returns old data and writes new.
    drive(1'b0, 1'b0, 1'b1, 7'd1, 32'hAAAA0000);
    drive(1'b0, 1'b0, 1'b0, 7'd1, 32'h00005555);
    check_eq("illegal_old", obs_rdata, 32'hAAAA0000);
    drive(1'b0, 1'b1, 1'b0, 7'd1, '0);
    check_eq("proto_err", 32'(obs_perr), 32'd1);
    check_eq("illegal_new", obs_rdata, 32'h00005555);

    // Access during sweep, then reset mid-sweep.
    rst_n = 1'b0; idle(); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) idle();
    drive(1'b0, 1'b0, 1'b1, 7'd2, 32'hCAFEF00D);
    idle(); check_eq("early_err", 32'(obs_eerr), 32'd1);
    for (int i = 12; i < 50; i++) idle();
    rst_n = 1'b0; idle(); rst_n = 1'b1;
    n = 0;
    do begin
      idle();
      if (obs_busy) n++;
    end while (obs_busy && n < 200);
    check_eq("resweep_len", n, DEPTH);
    check_eq("early_err_clr", 32'(obs_eerr), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 7'd2, '0); check_eq("dropped_a2", obs_rdata, 32'h0);

    // Randomized traffic with occasional reset; preload requests held until accepted.
    for (int i = 0; i < 3000; i++) begin
      logic c, w, o;
      rst_n = ($urandom_range(0, 399) != 0);
      if (!ld_valid && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b1; ld_addr = AW'($urandom_range(0, 15)); ld_data = $urandom;
      end
      c = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 2) != 0);
      o = ($urandom_range(0, 5) == 0) ? w : !w;
      drive(c, w, o, AW'($urandom_range(0, 15)), $urandom);
      if (ld_valid && obs_ld_ready) ld_valid = 1'b0;
    end
    ld_valid = 1'b0;

    // Read counter saturation.
    reset_and_sweep("sweep_len3");
    for (int i = 0; i < 65537; i++) drive(1'b0, 1'b1, 1'b0, AW'($urandom_range(0, 127)), '0);
    idle(); check_eq("rd_sat", 32'(obs_rd_cnt), 32'hFFFF);
    drive(1'b0, 1'b1, 1'b0, 7'd0, '0);
    idle(); check_eq("rd_sat_hold", 32'(obs_rd_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface: a DEPTH x DW word store answering the CPU's chip-enable, write-enable and output-enable strobes with a word address.
- Clears itself after reset with a sequential sweep. Offers a valid/ready preload port for the bench or boot loader, checks strobe protocol, and keeps access counters.
- Sits beside the single-cycle core, which drives CEN/WEN/OEN/A/Data2Mem and consumes ReadDataMem in the same cycle.

Parameters:
- DEPTH, 128, number of words.
- AW, 7, word-address width; DEPTH = 2**AW.
- DW, 32, data width.
- CW, 16, access-counter width.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset: synchronous, active-low.
- CEN, input, 1, chip enable, active-low.
- WEN, input, 1, write enable, active-low.
- OEN, input, 1, output enable, active-low.
- A, input, AW, word address.
- Data2Mem, input, DW, write data.
- ReadDataMem, output, DW, read data (combinational).
- ld_valid, input, 1, preload request.
- ld_ready, output, 1, preload accepted this cycle.
- ld_addr, input, AW, preload address.
- ld_data, input, DW, preload data.
- busy, output, 1, clear sweep in progress.
- proto_err, output, 1, sticky illegal-strobe flag.
- early_err, output, 1, sticky flag: CPU access during sweep.
- rd_cnt, output, CW, saturating count of CPU reads.
- wr_cnt, output, CW, saturating count of CPU writes.

Behaviour:
- Reset, sampled at a clk edge with rst_n=0:
  - state<=CLEAR, clr_addr<=0.
  - rd_cnt, wr_cnt, proto_err, early_err <= 0.
  - Array contents are not reset directly; the sweep zeroes them.
  - While rst_n=0, outputs are busy=1, ld_ready=0, ReadDataMem=0.
- States: CLEAR, READY.
- CLEAR:
  - Each cycle: mem[clr_addr]<=0 and clr_addr<=clr_addr+1.
  - When clr_addr==DEPTH-1 is written, go to READY.
  - The sweep takes exactly DEPTH cycles; busy=1 throughout.
- Reset reasserted in any state, including mid-sweep or mid-preload, restarts CLEAR from address 0.
- CPU access during CLEAR (CEN=0): writes are dropped, ReadDataMem=0, early_err<=1, counters unchanged.
- READY, CPU read (CEN=0, OEN=0, WEN=1):
  - ReadDataMem=mem[A] combinationally, zero latency.
  - rd_cnt increments at the edge.
- READY, CPU write (CEN=0, WEN=0, OEN=1):
  - mem[A]<=Data2Mem at the edge.
  - ReadDataMem=0.
  - wr_cnt increments.
- READY, CEN=0 with WEN=0 and OEN=0 (illegal):
  - The write is performed.
  - ReadDataMem shows the old mem[A] (pre-edge contents).
  - proto_err<=1; both counters increment.
- CEN=0 with WEN=1 and OEN=1: no access, ReadDataMem=0, no count.
- CEN=1: ReadDataMem=0 regardless of WEN/OEN; no error.
- Preload port:
  - ld_ready = (state==READY) & CEN, so the CPU always wins.
  - A transfer occurs when ld_valid & ld_ready at the edge: mem[ld_addr]<=ld_data.
  - A stalled request must hold ld_addr/ld_data until accepted.
- Write-then-read: a CPU or preload write at edge N is visible to a CPU read in cycle N+1.
- Counters saturate at 2**CW-1 and never wrap.
- Sticky flags clear only on reset.
- No address bounds error: A spans exactly DEPTH words.

Test Plan:
- Reset, then hold CEN=1 -> busy=1 for exactly 128 cycles, then 0. Subsequent reads of A=0, 5, 127 return 0.
- After sweep: write A=7, Data2Mem=0xDEADBEEF; next cycle read A=7 -> ReadDataMem=0xDEADBEEF, wr_cnt=1, rd_cnt=1.
- Preload ld_addr=3, ld_data=0x12345678 while CEN=0 for 2 cycles -> ld_ready=0, no write. CEN=1 -> accepted. CPU read A=3 -> 0x12345678.
- Write A=1 with 0xAAAA0000, then CEN=0, WEN=0, OEN=0, A=1, Data2Mem=0x5555 -> ReadDataMem=0xAAAA0000 that cycle, proto_err=1, next read A=1 -> 0x00005555.
- CPU write A=2 during sweep cycle 10 -> early_err=1, no write. After sweep, A=2 reads 0. Assert rst_n=0 at sweep cycle 50 -> sweep restarts, busy lasts 128 more cycles, early_err=0.
- Force 65537 reads -> rd_cnt stops at 0xFFFF.
